// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: unsigned binary to packed BCD plus a
// significant-digit count, one input bit consumed per clock.
`timescale 1ns/1ps
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int CW     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [CW-1:0]         ndigits
);

  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic [WIDTH-1:0]   sr;
  logic [BW-1:0]      acc;
  logic [CNT_W-1:0]   cnt;
  logic [BW-1:0]      acc_adj;
  logic [BW+WIDTH-1:0] shifted;
  logic [BW-1:0]      acc_nxt;
  logic [WIDTH-1:0]   sr_nxt;
  logic               last_bit;

  // Add 3 to every digit that is 5 or more so the following shift carries
  // correctly into the next decimal digit.
  function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // One plus the index of the highest nonzero digit; zero counts as one digit.
  function automatic logic [CW-1:0] count_digits(input logic [BW-1:0] a);
    logic [CW-1:0] n;
    n = CW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] != 4'd0)
        n = CW'(i + 1);
    end
    return n;
  endfunction

  // One double-dabble step: correct digits, then shift {acc, sr} left by one.
  always_comb begin
    acc_adj  = dabble_adjust(acc);
    shifted  = {acc_adj, sr} << 1;
    acc_nxt  = shifted[BW+WIDTH-1 -: BW];
    sr_nxt   = shifted[WIDTH-1:0];
    last_bit = (state == SHIFT) && (cnt == '0);
  end

  // Next-state and status decode; start is only honoured when not busy.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == '0)
          state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Shift register, accumulator and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= bin;
      acc <= '0;
      cnt <= CNT_W'(WIDTH - 1);
    end else if (state == SHIFT) begin
      sr  <= sr_nxt;
      acc <= acc_nxt;
      if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  // Result registers load only from the final step, so partial values never show.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd     <= '0;
      ndigits <= CW'(1);
    end else if (last_bit) begin
      bcd     <= acc_nxt;
      ndigits <= count_digits(acc_nxt);
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: reset, single and back-to-back conversions,
// start-while-busy, mid-conversion reset and a strided sweep against a
// decimal reference model.
`timescale 1ns/1ps
module tb_bin2bcd_seq;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int CW     = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic [CW-1:0]       ndigits;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ndigits(ndigits)
  );

  always #5 clk = ~clk;

  // Count every done pulse seen at a rising edge.
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int ref_nd(input int v);
    int n;
    int x;
    n = 1;
    x = v / 10;
    while (x > 0) begin
      n++;
      x = x / 10;
    end
    return n;
  endfunction

  // Edges after the accepting edge until done is seen (sampled #1 after each edge).
  task automatic wait_done(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        k = i;
        return;
      end
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_conv(input string tag, input int v,
                          input logic [4*DIGITS-1:0] eb, input int en);
    int k;
    int dc0;
    logic ok;
    bin = WIDTH'(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dc0 = done_cnt;
    wait_done(k);
    check({tag, "_latency"}, k, WIDTH);
    check({tag, "_bcd"}, bcd, eb);
    check({tag, "_nd"}, ndigits, en);
    ok = 1'b1;
    for (int d = 0; d < DIGITS; d++)
      if (bcd[4*d +: 4] > 4'd9) ok = 1'b0;
    check({tag, "_digit_le9"}, ok, 1'b1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_done_count"}, done_cnt - dc0, 1);
  endtask

  initial begin
    int k, k2, dc0;
    logic busy_ok;

    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state held over 5 idle cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_bcd", bcd, 20'h00000);
      check("rst_nd", ndigits, 3'd1);
    end
    check("rst_no_done", done_cnt, 0);

    // Single conversions
    run_conv("c1221",  1221,  20'h01221, 4);
    run_conv("c0",     0,     20'h00000, 1);
    run_conv("c100",   100,   20'h00100, 3);
    run_conv("c65535", 65535, 20'h65535, 5);
    run_conv("c9",     9,     20'h00009, 1);
    run_conv("c10",    10,    20'h00010, 2);

    // Back-to-back with start held high
    dc0 = done_cnt;
    bin = 16'd121; start = 1'b1;
    @(posedge clk); #1;
    wait_done(k);
    check("b2b_lat1", k, WIDTH);
    check("b2b_bcd1", bcd, 20'h00121);
    check("b2b_nd1", ndigits, 3'd3);
    bin = 16'd1001;
    @(posedge clk); #1;
    check("b2b_busy", busy, 1'b1);
    wait_done(k2);
    check("b2b_spacing", k2 + 1, WIDTH + 1);
    start = 1'b0;
    check("b2b_bcd2", bcd, 20'h01001);
    check("b2b_nd2", ndigits, 3'd4);
    @(posedge clk); #1;
    check("b2b_idle", busy, 1'b0);
    check("b2b_count", done_cnt - dc0, 2);

    // Start asserted while busy is ignored
    bin = 16'd4567; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dc0 = done_cnt;
    busy_ok = 1'b1;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        k = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (i == 5) begin
        start = 1'b1; bin = 16'd9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("swb_found_done", k != 0, 1'b1);
    check("swb_busy_held", busy_ok, 1'b1);
    check("swb_latency", k, WIDTH);
    check("swb_bcd", bcd, 20'h04567);
    check("swb_nd", ndigits, 3'd4);
    @(posedge clk); #1;
    check("swb_count", done_cnt - dc0, 1);
    check("swb_idle", busy, 1'b0);

    // Reset in the middle of a conversion
    bin = 16'd1234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dc0 = done_cnt;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_bcd", bcd, 20'h00000);
    check("mrst_nd", ndigits, 3'd1);
    repeat (20) @(posedge clk);
    #1;
    check("mrst_no_done", done_cnt - dc0, 0);
    run_conv("mrst_after", 1234, 20'h01234, 4);

    // Strided sweep against the decimal model, plus the top value
    for (int v = 0; v < 65536; v += 23)
      run_conv("sweep", v, ref_bcd(v), ref_nd(v));
    run_conv("sweep_max", 65535, ref_bcd(65535), ref_nd(65535));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
